// File: rtl/can_frame_tx_if.sv
// ----------------------------------------------------------------------------
// can_frame_tx_if
//   Bundles the frame-builder handshake and the transceiver-side bus bits of
//   the CAN frame transmitter.
//
//   master : frame builder / bus side (drives the request, frame and CAN_RX;
//            observes the transmitter status)
//   slave  : can_frame_tx
//
//   Signals
//     start      request a transmission (sampled on sp)
//     frame      right-justified frame bits, frame[frame_len-1] is SOF
//     frame_len  number of data bits to send
//     stuff_len  number of leading data bits subject to bit stuffing
//     CAN_RX     bus value at the sample point
//     CAN_TX     driven bus bit, 1 = recessive
//     isStuff    current CAN_TX bit is a stuff bit
//     busy       transmission in progress
//     done       one-bit-time pulse on normal completion
//     arb_lost   one-bit-time pulse on arbitration loss
// ----------------------------------------------------------------------------
interface can_frame_tx_if #(
    parameter int FRAME_W = 151,
    parameter int LEN_W   = 8
);
    logic               start;
    logic [FRAME_W-1:0] frame;
    logic [LEN_W-1:0]   frame_len;
    logic [LEN_W-1:0]   stuff_len;
    logic               CAN_RX;
    logic               CAN_TX;
    logic               isStuff;
    logic               busy;
    logic               done;
    logic               arb_lost;

    modport master (
        output start, frame, frame_len, stuff_len, CAN_RX,
        input  CAN_TX, isStuff, busy, done, arb_lost
    );

    modport slave (
        input  start, frame, frame_len, stuff_len, CAN_RX,
        output CAN_TX, isStuff, busy, done, arb_lost
    );
endinterface

// File: rtl/can_frame_tx.sv
// ----------------------------------------------------------------------------
// can_frame_tx
//   Serializes a preassembled CAN frame onto CAN_TX, MSB first, one bit per
//   rising edge of sp. Inside the stuffed region (the first eff_stuff data
//   bits, eff_stuff = min(stuff_len, frame_len)) a complement bit is inserted
//   after every run of five identical bus bits and flagged on isStuff.
//
//   Ports
//     sp     clock, one rising edge per CAN bit time
//     reset  asynchronous, active-high; aborts any frame in progress
//     bus    can_frame_tx_if.slave (start/frame/frame_len/stuff_len/CAN_RX in,
//            CAN_TX/isStuff/busy/done/arb_lost out)
//
//   Parameters
//     FRAME_W   width of the frame vector
//     LEN_W     width of frame_len / stuff_len
//     ARB_BITS  leading data bits that form the arbitration field
//
//   Build option
//     CAN_FRAME_TX_ARB_EN  when defined, CAN_RX is compared with a recessive
//                          CAN_TX during arbitration-field data bits and a
//                          dominant readback aborts the frame with arb_lost.
//                          When undefined, CAN_RX is ignored and arb_lost
//                          stays 0.
// ----------------------------------------------------------------------------
module can_frame_tx #(
    parameter int FRAME_W  = 151,
    parameter int LEN_W    = 8,
    parameter int ARB_BITS = 12
) (
    input  logic         sp,
    input  logic         reset,
    can_frame_tx_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEND  = 2'd1,
        STUFF = 2'd2
    } state_t;

    localparam logic [LEN_W-1:0] ONE     = LEN_W'(1);
    localparam logic [LEN_W-1:0] ARB_LIM = LEN_W'(ARB_BITS);

    // Run length of identical bus bits; saturates so that long runs outside
    // the stuffed region cannot wrap back into a false count.
    function automatic logic [2:0] run_inc(input logic [2:0] r);
        return (r == 3'd7) ? r : r + 3'd1;
    endfunction

    function automatic logic [LEN_W-1:0] len_min(input logic [LEN_W-1:0] a,
                                                 input logic [LEN_W-1:0] b);
        return (a < b) ? a : b;
    endfunction

    state_t             state, state_nxt;
    logic [2:0]         run, run_nxt;
    logic               tx, tx_nxt;
    logic               stuff, stuff_nxt;
    logic               busy, busy_nxt;
    logic               done, done_nxt;
    logic               arb, arb_nxt;

    logic [FRAME_W-1:0] frame_q;
    logic [LEN_W-1:0]   len_q;
    logic [LEN_W-1:0]   eff_stuff_q;
    logic [LEN_W-1:0]   idx, idx_nxt;

    logic               accept;
    logic [LEN_W-1:0]   pos;
    logic [LEN_W-1:0]   idx_m1;
    logic               in_region;
    logic               stuff_now;
    logic               last_bit;
    logic               next_bit;
    logic               first_bit;
    logic               arb_hit;

    // ---- decode of the current bit time -------------------------------------
    // pos is the zero-based position of the data bit now on the bus.
    assign accept    = (state == IDLE) && bus.start && (bus.frame_len != '0);
    assign pos       = len_q - idx - ONE;
    assign idx_m1    = idx - ONE;
    assign in_region = (pos < eff_stuff_q);
    assign stuff_now = (state == SEND) && in_region && (run == 3'd5);
    assign last_bit  = (idx == '0);
    assign next_bit  = frame_q[idx_m1];
    assign first_bit = bus.frame[bus.frame_len - ONE];

`ifdef CAN_FRAME_TX_ARB_EN
    // Only data bits (SEND) of the arbitration field are checked; a recessive
    // bit read back dominant means another node won the bus.
    assign arb_hit = (state == SEND) && (pos < ARB_LIM) && tx && !bus.CAN_RX;
`else
    logic arb_unused;
    assign arb_unused = bus.CAN_RX ^ ARB_LIM[0];
    assign arb_hit    = 1'b0;
`endif

    // ---- state and registered outputs ---------------------------------------
    always_ff @(posedge sp or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            run   <= 3'd0;
            tx    <= 1'b1;
            stuff <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            arb   <= 1'b0;
        end else begin
            state <= state_nxt;
            run   <= run_nxt;
            tx    <= tx_nxt;
            stuff <= stuff_nxt;
            busy  <= busy_nxt;
            done  <= done_nxt;
            arb   <= arb_nxt;
        end
    end

    // Frame data and bit index only matter while busy, so they are loaded on
    // acceptance and carry no reset.
    always_ff @(posedge sp) begin
        if (accept) begin
            frame_q     <= bus.frame;
            len_q       <= bus.frame_len;
            eff_stuff_q <= len_min(bus.stuff_len, bus.frame_len);
        end
        idx <= idx_nxt;
    end

    // ---- next state ----------------------------------------------------------
    // A pending stuff bit takes priority over finishing, so a run completed on
    // the last stuffed bit still gets its stuff bit before done.
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        run_nxt   = run;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = SEND;
                    idx_nxt   = bus.frame_len - ONE;
                    run_nxt   = 3'd1;
                end
            end
            SEND: begin
                if (arb_hit) begin
                    state_nxt = IDLE;
                    run_nxt   = 3'd0;
                end else if (stuff_now) begin
                    state_nxt = STUFF;
                    run_nxt   = 3'd1;
                end else if (last_bit) begin
                    state_nxt = IDLE;
                    run_nxt   = 3'd0;
                end else begin
                    idx_nxt = idx_m1;
                    run_nxt = (next_bit == tx) ? run_inc(run) : 3'd1;
                end
            end
            STUFF: begin
                if (last_bit) begin
                    state_nxt = IDLE;
                    run_nxt   = 3'd0;
                end else begin
                    state_nxt = SEND;
                    idx_nxt   = idx_m1;
                    run_nxt   = (next_bit == tx) ? 3'd2 : 3'd1;
                end
            end
            default: begin
                state_nxt = IDLE;
                run_nxt   = 3'd0;
            end
        endcase
    end

    // ---- next outputs --------------------------------------------------------
    always_comb begin
        tx_nxt    = 1'b1;
        stuff_nxt = 1'b0;
        busy_nxt  = 1'b0;
        done_nxt  = 1'b0;
        arb_nxt   = 1'b0;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    tx_nxt   = first_bit;
                    busy_nxt = 1'b1;
                end
            end
            SEND: begin
                if (arb_hit) begin
                    arb_nxt = 1'b1;
                end else if (stuff_now) begin
                    tx_nxt    = ~tx;
                    stuff_nxt = 1'b1;
                    busy_nxt  = 1'b1;
                end else if (last_bit) begin
                    done_nxt = 1'b1;
                end else begin
                    tx_nxt   = next_bit;
                    busy_nxt = 1'b1;
                end
            end
            STUFF: begin
                if (last_bit) begin
                    done_nxt = 1'b1;
                end else begin
                    tx_nxt   = next_bit;
                    busy_nxt = 1'b1;
                end
            end
            default: begin
                tx_nxt = 1'b1;
            end
        endcase
    end

    assign bus.CAN_TX   = tx;
    assign bus.isStuff  = stuff;
    assign bus.busy     = busy;
    assign bus.done     = done;
    assign bus.arb_lost = arb;

endmodule

// File: tb/tb_can_frame_tx.sv
// ----------------------------------------------------------------------------
// tb_can_frame_tx
//   Self-checking bench for can_frame_tx. Expected bus sequences come from a
//   bit-stuffing reference model that walks the data bits and inserts a
//   complement after five equal bus bits inside the stuffed prefix.
// ----------------------------------------------------------------------------
module tb_can_frame_tx;

    localparam int FW  = 151;
    localparam int LW  = 8;
    localparam int ARB = 12;

    logic sp;
    logic reset;

    can_frame_tx_if #(.FRAME_W(FW), .LEN_W(LW)) bus ();

    can_frame_tx #(.FRAME_W(FW), .LEN_W(LW), .ARB_BITS(ARB)) dut (
        .sp    (sp),
        .reset (reset),
        .bus   (bus.slave)
    );

    int checks = 0;
    int errors = 0;

    // reference model output: one entry per bus bit time
    bit exp_tx[$];
    bit exp_st[$];
    int exp_pos[$];

    initial begin
        sp = 1'b0;
        forever #5 sp = ~sp;
    end

    task automatic tick();
        @(posedge sp);
        #1;
    endtask

    function automatic logic [4:0] obs();
        return {bus.CAN_TX, bus.isStuff, bus.busy, bus.done, bus.arb_lost};
    endfunction

    function automatic void build_model(input logic [FW-1:0] f, input int len, input int slen);
        int eff;
        int run;
        bit last;
        bit b;
        exp_tx.delete();
        exp_st.delete();
        exp_pos.delete();
        eff  = (slen < len) ? slen : len;
        run  = 0;
        last = 1'b0;
        for (int p = 0; p < len; p++) begin
            b = f[len-1-p];
            exp_tx.push_back(b);
            exp_st.push_back(1'b0);
            exp_pos.push_back(p);
            if (p > 0 && b == last) run++;
            else run = 1;
            last = b;
            if (p < eff && run == 5) begin
                exp_tx.push_back(~b);
                exp_st.push_back(1'b1);
                exp_pos.push_back(-1);
                last = ~b;
                run  = 1;
            end
        end
    endfunction

    function automatic logic [FW-1:0] rand_frame();
        logic [FW-1:0] f;
        bit b;
        b = 1'($urandom_range(0, 1));
        for (int i = FW - 1; i >= 0; i--) begin
            if ($urandom_range(0, 3) == 0) b = ~b;
            f[i] = b;
        end
        return f;
    endfunction

    // Sends one frame and checks every bit time; rx_low_pos selects a data
    // bit during which CAN_RX is pulled dominant (-1 for none).
    task automatic test_frame(input string name, input logic [FW-1:0] f,
                              input int len, input int slen, input int rx_low_pos);
        logic [4:0] exp;
        logic [4:0] got;
        bit aborted;
        bit expect_abort;
        build_model(f, len, slen);
        bus.frame     = f;
        bus.frame_len = LW'(len);
        bus.stuff_len = LW'(slen);
        bus.CAN_RX    = 1'b1;
        bus.start     = 1'b1;
        aborted       = 1'b0;
        for (int k = 0; k < exp_tx.size() && !aborted; k++) begin
            tick();
            bus.start  = 1'b0;
            bus.frame  = ~f;
            bus.CAN_RX = 1'b1;
            exp = {exp_tx[k], exp_st[k], 1'b1, 1'b0, 1'b0};
            got = obs();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL %s bit %0d: tx/st/busy/done/arb got %b expected %b", name, k, got, exp);
            end
            if (exp_pos[k] == rx_low_pos) begin
                bus.CAN_RX = 1'b0;
                expect_abort = 1'b0;
`ifdef CAN_FRAME_TX_ARB_EN
                expect_abort = (rx_low_pos < ARB) && exp_tx[k];
`endif
                if (expect_abort) begin
                    tick();
                    bus.CAN_RX = 1'b1;
                    got = obs();
                    checks++;
                    if (got !== 5'b10001) begin
                        errors++;
                        $display("FAIL %s arb_lost edge: got %b expected %b", name, got, 5'b10001);
                    end
                    tick();
                    got = obs();
                    checks++;
                    if (got !== 5'b10000) begin
                        errors++;
                        $display("FAIL %s after arb_lost: got %b expected %b", name, got, 5'b10000);
                    end
                    aborted = 1'b1;
                end
            end
        end
        if (!aborted) begin
            tick();
            bus.CAN_RX = 1'b1;
            got = obs();
            checks++;
            if (got !== 5'b10010) begin
                errors++;
                $display("FAIL %s done edge: got %b expected %b", name, got, 5'b10010);
            end
            tick();
            got = obs();
            checks++;
            if (got !== 5'b10000) begin
                errors++;
                $display("FAIL %s after done: got %b expected %b", name, got, 5'b10000);
            end
        end
    endtask

    task automatic test_reset();
        logic [4:0] got;
        bus.start     = 1'b0;
        bus.frame     = '0;
        bus.frame_len = '0;
        bus.stuff_len = '0;
        bus.CAN_RX    = 1'b1;
        reset = 1'b1;
        tick();
        tick();
        got = obs();
        checks++;
        if (got !== 5'b10000) begin
            errors++;
            $display("FAIL reset_state: got %b expected %b", got, 5'b10000);
        end
        reset = 1'b0;
        // start with frame_len 0 must be ignored
        bus.start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            got = obs();
            checks++;
            if (got !== 5'b10000) begin
                errors++;
                $display("FAIL zero_len_start cycle %0d: got %b expected %b", i, got, 5'b10000);
            end
        end
        bus.start = 1'b0;
        tick();
    endtask

    task automatic test_directed();
        test_frame("stuff_mid", FW'(8'b0000_0011), 8, 8, -1);
        test_frame("no_stuff_region", FW'(10'b00000_00000), 10, 4, -1);
        test_frame("stuff_before_last", FW'(6'b111110), 6, 6, -1);
        test_frame("stuff_after_last", FW'(5'b00000), 5, 5, -1);
        test_frame("single_bit", FW'(1'b1), 1, 1, -1);
    endtask

    task automatic test_random();
        for (int n = 0; n < 12; n++) begin
            test_frame("random", rand_frame(), $urandom_range(1, FW),
                       $urandom_range(0, 255), -1);
        end
    endtask

    task automatic test_back_to_back();
        logic [FW-1:0] fa;
        logic [FW-1:0] fb;
        logic [4:0] exp;
        logic [4:0] got;
        int nb;
        fa = FW'(8'b0000_0000);
        fb = rand_frame();
        nb = 16;
        build_model(fa, 8, 8);
        bus.frame     = fa;
        bus.frame_len = 8'd8;
        bus.stuff_len = 8'd8;
        bus.CAN_RX    = 1'b1;
        bus.start     = 1'b1;
        for (int k = 0; k < exp_tx.size(); k++) begin
            tick();
            // start stays high and the inputs switch to frame B mid-frame
            bus.frame     = fb;
            bus.frame_len = LW'(nb);
            bus.stuff_len = LW'(nb);
            exp = {exp_tx[k], exp_st[k], 1'b1, 1'b0, 1'b0};
            got = obs();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL b2b_first bit %0d: got %b expected %b", k, got, exp);
            end
        end
        tick();
        got = obs();
        checks++;
        if (got !== 5'b10010) begin
            errors++;
            $display("FAIL b2b_done: got %b expected %b", got, 5'b10010);
        end
        build_model(fb, nb, nb);
        for (int k = 0; k < exp_tx.size(); k++) begin
            tick();
            bus.start = 1'b0;
            exp = {exp_tx[k], exp_st[k], 1'b1, 1'b0, 1'b0};
            got = obs();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL b2b_second bit %0d: got %b expected %b", k, got, exp);
            end
        end
        tick();
        got = obs();
        checks++;
        if (got !== 5'b10010) begin
            errors++;
            $display("FAIL b2b_second_done: got %b expected %b", got, 5'b10010);
        end
        tick();
    endtask

    task automatic test_reset_abort();
        logic [FW-1:0] f;
        logic [4:0] got;
        f = FW'(20'b0101_1010_0110_1001_0110);
        bus.frame     = f;
        bus.frame_len = 8'd20;
        bus.stuff_len = 8'd20;
        bus.start     = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        #2;
        reset = 1'b1;
        #1;
        got = obs();
        checks++;
        if (got !== 5'b10000) begin
            errors++;
            $display("FAIL reset_abort_immediate: got %b expected %b", got, 5'b10000);
        end
        tick();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            got = obs();
            checks++;
            if (got !== 5'b10000) begin
                errors++;
                $display("FAIL reset_abort_idle cycle %0d: got %b expected %b", i, got, 5'b10000);
            end
        end
        test_frame("after_reset", f, 20, 20, -1);
    endtask

    task automatic test_arb();
        logic [FW-1:0] f;
        f = '0;
        // alternating bits, position 4 forced recessive; positions 4 and 15
        // are both recessive and no run reaches five
        for (int p = 0; p < 20; p++) begin
            f[19-p] = (p == 4) ? 1'b1 : 1'(p % 2);
        end
        test_frame("arb_bit4", f, 20, 20, 4);
        test_frame("arb_bit15", f, 20, 20, 15);
        test_frame("after_arb", rand_frame(), 40, 40, -1);
    endtask

    initial begin
        reset = 1'b1;
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_reset_abort();
        test_arb();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
